// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after start_i, modulo num_req_p,
// skipping any requester marked in excl_i.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned num_req_p = 4
) (
    input  logic [num_req_p-1:0]         req_i,
    input  logic [$clog2(num_req_p)-1:0] start_i,
    input  logic [num_req_p-1:0]         excl_i,
    output logic                         found_o,
    output logic [$clog2(num_req_p)-1:0] idx_o
);

    localparam int unsigned IdxW = width_of(num_req_p);

    logic [num_req_p-1:0] w_cand;
    logic [IdxW-1:0]      w_k;

    assign w_cand = req_i & ~excl_i;

    // Scan from the far end back toward start_i so the last hit is the nearest one.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_k     = '0;
        for (int i = int'(num_req_p) - 1; i >= 0; i--) begin
            w_k = IdxW'((int'(start_i) + i) % int'(num_req_p));
            if (w_cand[w_k]) begin
                found_o = 1'b1;
                idx_o   = w_k;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among num_req_p requesters.
// Data path is purely combinational; only grant, pointer and beat count are registered.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned width_p     = 32,
    parameter int unsigned num_req_p   = 4,
    parameter int unsigned burst_max_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_valid_i,
    input  logic [num_req_p*width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]           req_last_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           fifo_valid_o,
    output logic [width_p-1:0]             fifo_data_o,
    input  logic                           fifo_ready_i,
    output logic [num_req_p-1:0]           grant_o,
    output logic [$clog2(num_req_p)-1:0]   grant_id_o
);

    localparam int unsigned IdxW = width_of(num_req_p);
    localparam int unsigned CntW = width_of(burst_max_p + 1);

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [IdxW-1:0]      r_grant_id;
    logic [IdxW-1:0]      w_grant_id_next;
    logic [IdxW-1:0]      r_rr_ptr;
    logic [IdxW-1:0]      w_rr_ptr_next;
    logic [CntW-1:0]      r_beat_cnt;
    logic [CntW-1:0]      w_beat_cnt_next;

    logic                 w_busy;
    logic [num_req_p-1:0] w_grant_oh;
    logic [IdxW-1:0]      w_grant_inc;
    logic                 w_g_valid;
    logic                 w_g_last;
    logic                 w_beat;
    logic                 w_cap;
    logic                 w_release;
    logic [IdxW-1:0]      w_pick_start;
    logic [num_req_p-1:0] w_pick_excl;
    logic                 w_pick_found;
    logic [IdxW-1:0]      w_pick_idx;

    assign w_busy      = (r_state == BUSY);
    assign w_grant_oh  = {{(num_req_p-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_grant_inc = (r_grant_id == IdxW'(num_req_p - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_g_valid   = req_valid_i[r_grant_id];
    assign w_g_last    = req_last_i[r_grant_id];

    assign w_beat    = w_busy & w_g_valid & fifo_ready_i;
    assign w_cap     = (r_beat_cnt == CntW'(burst_max_p - 1));
    assign w_release = w_busy & (~w_g_valid | (w_beat & (w_g_last | w_cap)));

    // One picker serves both IDLE arbitration and the release re-pick. The outgoing
    // requester is only excluded when it actually completed a beat (last or cap).
    assign w_pick_start = w_busy ? w_grant_inc : r_rr_ptr;
    assign w_pick_excl  = w_beat ? w_grant_oh : '0;

    rr_picker #(
        .num_req_p (num_req_p)
    ) u_picker (
        .req_i   (req_valid_i),
        .start_i (w_pick_start),
        .excl_i  (w_pick_excl),
        .found_o (w_pick_found),
        .idx_o   (w_pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_id_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_id_next = r_grant_id;
        w_rr_ptr_next   = r_rr_ptr;
        w_beat_cnt_next = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_next    = BUSY;
                    w_grant_id_next = w_pick_idx;
                    w_beat_cnt_next = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_rr_ptr_next   = w_grant_inc;
                    w_beat_cnt_next = '0;
                    if (w_pick_found) begin
                        w_grant_id_next = w_pick_idx;
                    end else begin
                        w_state_next    = IDLE;
                        w_grant_id_next = '0;
                    end
                end else if (w_beat) begin
                    w_beat_cnt_next = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_o      = '0;
        grant_id_o   = '0;
        fifo_valid_o = 1'b0;
        fifo_data_o  = '0;
        req_ready_o  = '0;
        if (w_busy) begin
            grant_o      = w_grant_oh;
            grant_id_o   = r_grant_id;
            fifo_valid_o = w_g_valid;
            fifo_data_o  = req_data_i[r_grant_id*width_p +: width_p];
            req_ready_o  = fifo_ready_i ? w_grant_oh : '0;
        end
    end

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_o));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        r_beat_cnt <= CntW'(burst_max_p - 1));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed vector tables plus a reference-model scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned B  = 8;
    localparam int unsigned IW = 2;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           fifo_valid_o;
    logic [W-1:0]   fifo_data_o;
    logic           fifo_ready_i;
    logic [N-1:0]   grant_o;
    logic [IW-1:0]  grant_id_o;

    always #5 clk_i = ~clk_i;

    fifo_wr_arbiter #(
        .width_p     (W),
        .num_req_p   (N),
        .burst_max_p (B)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .fifo_valid_o (fifo_valid_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_ready_i (fifo_ready_i),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [IW-1:0] gid;
        logic          fv;
        logic [W-1:0]  data;
        logic [N-1:0]  rdy;
    } exp_t;

    typedef struct {
        logic [N-1:0]  v;
        logic [N-1:0]  l;
        logic          rdy;
        logic [N-1:0]  eg;
        logic [IW-1:0] egid;
        logic          efv;
        logic [N-1:0]  erd;
    } vec_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    task automatic model_pick(input logic [N-1:0] v, input int start, input int skip,
                              output bit found, output int idx);
        found = 0;
        idx   = 0;
        for (int o = 0; o < int'(N); o++) begin
            int k = (start + o) % int'(N);
            if (!found && v[k] && k != skip) begin
                found = 1;
                idx   = k;
            end
        end
    endtask

    // Drive one cycle, push the expectation, advance the model, compare at negedge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy,
                        input logic rst, input bit use_tbl, input logic [N-1:0] tg,
                        input logic [IW-1:0] tgid, input logic tfv, input logic [N-1:0] trd,
                        input string tag);
        exp_t e;
        exp_t x;
        bit   found;
        int   idx;
        bit   beat;
        bit   rel;
        req_valid_i  = v;
        req_last_i   = l;
        fifo_ready_i = rdy;
        reset_i      = rst;
        for (int k = 0; k < int'(N); k++) req_data_i[k*W +: W] = $urandom;
        if (use_tbl) begin
            e.grant = tg;
            e.gid   = tgid;
            e.fv    = tfv;
            e.rdy   = trd;
            e.data  = (tg != '0) ? slice_of(req_data_i, int'(tgid)) : '0;
        end else if (m_busy) begin
            e.grant       = '0;
            e.grant[m_g]  = 1'b1;
            e.gid         = IW'(m_g);
            e.fv          = v[m_g];
            e.data        = slice_of(req_data_i, m_g);
            e.rdy         = '0;
            e.rdy[m_g]    = rdy;
        end else begin
            e.grant = '0;
            e.gid   = '0;
            e.fv    = 1'b0;
            e.data  = '0;
            e.rdy   = '0;
        end
        sb_q.push_back(e);
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_g = 0;
        end else if (!m_busy) begin
            model_pick(v, m_ptr, -1, found, idx);
            if (found) begin
                m_busy = 1; m_g = idx; m_cnt = 0;
            end
        end else begin
            beat = v[m_g] && rdy;
            rel  = !v[m_g] || (beat && (l[m_g] || m_cnt == int'(B) - 1));
            if (rel) begin
                m_ptr = (m_g + 1) % int'(N);
                model_pick(v, m_ptr, beat ? m_g : -1, found, idx);
                m_cnt = 0;
                if (found) m_g = idx;
                else begin
                    m_busy = 0; m_g = 0;
                end
            end else if (beat) begin
                m_cnt++;
            end
        end
        @(negedge clk_i);
        x = sb_q.pop_front();
        check({tag, " grant"}, grant_o, x.grant);
        check({tag, " grant_id"}, grant_id_o, x.gid);
        check({tag, " fifo_valid"}, fifo_valid_o, x.fv);
        check({tag, " fifo_data"}, fifo_data_o, x.data);
        check({tag, " req_ready"}, req_ready_o, x.rdy);
        @(posedge clk_i);
        #1;
    endtask

    task automatic mstep(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy,
                         input logic rst, input string tag);
        step(v, l, rdy, rst, 1'b0, '0, '0, 1'b0, '0, tag);
    endtask

    task automatic tstep(input logic [N-1:0] v, input logic rdy, input logic rst,
                         input logic [N-1:0] eg, input logic [IW-1:0] egid, input string tag);
        step(v, '0, rdy, rst, 1'b1, eg, egid, eg != '0, rdy ? eg : '0, tag);
    endtask

    vec_t tbl[12];

    initial begin
        logic [N-1:0]  eg;
        logic [IW-1:0] egid;
        logic          rdy;
        logic          rst;

        // Release of req1 (last) hands to req3; bubble on req0 hands to req1 same cycle.
        tbl[0]  = '{4'b1010, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tbl[3]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tbl[4]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tbl[5]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0001};
        tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tbl[9]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0010};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};

        reset_i      = 1'b1;
        req_valid_i  = '0;
        req_last_i   = '0;
        req_data_i   = '0;
        fifo_ready_i = 1'b1;
        m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        for (int c = 0; c < 10; c++) mstep('0, '0, 1'b1, 1'b0, $sformatf("idle%0d", c));

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].rdy, 1'b0, 1'b1, tbl[i].eg, tbl[i].egid,
                 tbl[i].efv, tbl[i].erd, $sformatf("tbl%0d", i));
        end

        // Two requesters streaming: 8 beats each, no dead cycle between grants.
        mstep('0, '0, 1'b1, 1'b1, "rst_a");
        for (int c = 0; c < 25; c++) begin
            eg   = (c == 0) ? 4'b0000 : ((((c - 1) / 8) % 2 == 0) ? 4'b0001 : 4'b0100);
            egid = (eg == 4'b0100) ? 2'd2 : 2'd0;
            tstep(4'b0101, 1'b1, 1'b0, eg, egid, $sformatf("burst%0d", c));
        end

        // Backpressure after beat 4: hold 5 cycles, then exactly 4 more beats.
        mstep('0, '0, 1'b1, 1'b1, "rst_b");
        for (int c = 0; c < 16; c++) begin
            rdy = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
            eg  = (c == 0 || c == 14) ? 4'b0000 : 4'b0001;
            tstep(4'b0001, rdy, 1'b0, eg, 2'd0, $sformatf("stall%0d", c));
        end

        // Reset mid-burst of req1: grant drops next cycle and req0 wins afterwards.
        mstep('0, '0, 1'b1, 1'b1, "rst_c");
        for (int c = 0; c < 13; c++) begin
            rst = (c == 10);
            if (c == 0 || c == 11)      eg = 4'b0000;
            else if (c == 9 || c == 10) eg = 4'b0010;
            else                        eg = 4'b0001;
            egid = (eg == 4'b0010) ? 2'd1 : 2'd0;
            tstep(4'b1111, 1'b1, rst, eg, egid, $sformatf("midrst%0d", c));
        end

        mstep('0, '0, 1'b1, 1'b1, "rst_d");
        for (int c = 0; c < 300; c++) begin
            mstep(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) == 0, $sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
